fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction-fetch stage that sits directly upstream of the dual-port memory's port 0. It drives doubleword read requests into the memory, splits each returned 64-bit doubleword into big-endian 32-bit instructions, and buffers them with their PCs in a small circular queue. A valid/ready handshake drains the queue into decode. A redirect input retargets fetch and flushes all buffered and in-flight work.

## Interface
- QDEPTH, 4: queue entries; power of two, at least 2.
- RESET_PC, 64'h0: fetch address after reset; bits [1:0] ignored.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- memReadEn  out  1  connects to memory readEn0.
- memReadAddr  out  [63:3]  connects to memory readAddr0.
- memReadData  in  64  connects to memory readData0; valid in the cycle after an issuing edge.
- redirect  in  1  retarget fetch this cycle.
- redirectPc  in  [63:2]  new fetch word address.
- outValid  out  1  head entry valid.
- outReady  in  1  consumer accepts the head entry.
- outPc  out  64  PC of head instruction, {pc[63:2], 2'b00}.
- outInst  out  32  head instruction.

## Operation
- **State:** fetchPc[63:2], pendingValid, pendingPc[63:2], queue storage of {pc[63:2], inst[31:0]}, head and tail pointers (mod QDEPTH), count (0..QDEPTH).
- **Issue condition:** memReadEn = rst_n && !redirect && (count + 2*pendingValid <= QDEPTH-2). memReadAddr = fetchPc[63:3] at all times.
- **On an issuing edge:**
  - pendingValid <= 1 and pendingPc <= fetchPc.
  - fetchPc <= {fetchPc[63:3]+1, 1'b0}, wrapping modulo 2^61.
- **On a non-issuing edge:** pendingValid <= 0.
- **Response:** when pendingValid = 1, push into the queue at that edge.
  - If pendingPc[2] = 0, push two entries in order: (pc {pendingPc[63:3],0}, memReadData[63:32]) then (pc {pendingPc[63:3],1}, memReadData[31:0]).
  - If pendingPc[2] = 1, push one entry: (pendingPc, memReadData[31:0]).
- **Pop:** occurs on an edge where outValid && outReady. Push and pop may happen on the same edge. count' = count + pushes − pop. The issue rule guarantees a push never overflows.
- **Outputs:** outValid = (count != 0). outPc and outInst are driven combinationally from the head entry.
- **Redirect (dominates everything):**
  - On an edge where redirect = 1: count, head and tail <= 0; pendingValid <= 0, so the in-flight response is discarded; fetchPc <= redirectPc.
  - Any concurrent pop or push is void, and the consumer must not treat the popped entry as retired.
  - Back-to-back redirects: the last one wins.
- **Reset (rst_n low, immediate, asynchronous):**
  - fetchPc = RESET_PC[63:2]; pendingValid = 0; count, head and tail = 0; queue storage = 0.
  - Resulting outputs: outValid = 0, outPc = 0, outInst = 0, memReadEn = 0, memReadAddr = RESET_PC[63:3].
  - Reset mid-operation discards the queue and any in-flight data. The memory's stale readData0 is never consumed, because pendingValid = 0.

## Timing
- **Fetch latency:** issue at edge E; memory data is valid during the following cycle and is pushed at edge E+1. outValid is high after E+1, giving a 2-edge fetch-to-valid latency.
- **First fetch after reset:** the first rising edge with rst_n high is an issuing edge.
- **Redirect latency:** redirect sampled at edge R; the first new issue is at R+1; the first new instruction is valid after R+2.
- **Steady state:** with outReady = 1 and QDEPTH = 4, one doubleword is issued every other cycle, sustaining 2 instructions per 2 cycles. outValid may drop for one cycle between groups.
- **Backpressure:** with outReady = 0, at most QDEPTH entries are held. memReadEn stays 0 until space frees, and no instruction is lost or reordered.

## Test plan
- **Sequential fetch:** RESET_PC=0, mem[0]=64'h11111111_22222222, mem[1]=64'h33333333_44444444, outReady=1 -> outputs in order (0x0, 0x11111111), (0x4, 0x22222222), (0x8, 0x33333333), (0xC, 0x44444444). First outValid occurs 2 edges after reset release.
- **Odd-word redirect:** redirect to pc 0x14, with mem[2]=64'hAAAAAAAA_BBBBBBBB and mem[3]=64'hCCCCCCCC_DDDDDDDD -> first output (0x14, 0xBBBBBBBB), then (0x18, 0xCCCCCCCC). No entry for pc 0x10 appears.
- **Backpressure:** hold outReady=0 -> count saturates at 4 and memReadEn stays 0. Then release -> the 4 held entries appear in order, followed by pc 0x10 onward, with no gaps or duplicates.
- **Redirect with full queue and request in flight:** redirect to 0x40 -> next valid output is pc 0x40. No old-stream PC appears afterward, and count is 0 for the cycle after redirect.
- **Async reset mid-stream:** drop rst_n between edges -> outValid and memReadEn fall to 0 without waiting for a clock edge. After release, fetch restarts at RESET_PC.
- **Simultaneous push/pop at boundary:** count=2 with a two-instruction push arriving and outReady=1 -> count becomes 3. The head advances by one and the pointers wrap correctly past index 3.

Source files
------------

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_queue                                                  |
// | Description : Doubleword instruction fetch with big-endian word split and |
// |               a small circular queue feeding decode via valid/ready.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_queue #(
  parameter int          QDEPTH   = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         memReadEn,
  output logic [63:3]  memReadAddr,
  input  logic [63:0]  memReadData,
  input  logic         redirect,
  input  logic [63:2]  redirectPc,
  output logic         outValid,
  input  logic         outReady,
  output logic [63:0]  outPc,
  output logic [31:0]  outInst
);

  localparam int c_PTR_W = $clog2(QDEPTH);
  localparam int c_CNT_W = $clog2(QDEPTH + 1);
  localparam int c_OCC_W = c_CNT_W + 2;
  localparam logic [c_OCC_W-1:0] c_ISSUE_LIMIT = c_OCC_W'(QDEPTH - 2);

  logic [63:2]        r_fetchPc;
  logic               r_pendingValid;
  logic [63:2]        r_pendingPc;
  logic [63:2]        r_qPc   [QDEPTH];
  logic [31:0]        r_qInst [QDEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;

  logic [c_OCC_W-1:0] w_occupancy;
  logic               w_issue;
  logic               w_pop;
  logic               w_pushTwo;
  logic               w_pushOne;
  logic [c_CNT_W-1:0] w_pushCount;
  logic [c_PTR_W-1:0] w_tailNext1;

  // Reserve room for the in-flight doubleword so a response can never overflow.
  assign w_occupancy = c_OCC_W'(r_count) + (r_pendingValid ? c_OCC_W'(2) : c_OCC_W'(0));
  assign w_issue     = rst_n && !redirect && (w_occupancy <= c_ISSUE_LIMIT);
  assign w_pop       = outValid && outReady;
  assign w_pushTwo   = r_pendingValid && !r_pendingPc[2];
  assign w_pushOne   = r_pendingValid &&  r_pendingPc[2];
  assign w_pushCount = w_pushTwo ? c_CNT_W'(2) : (w_pushOne ? c_CNT_W'(1) : c_CNT_W'(0));
  assign w_tailNext1 = r_tail + c_PTR_W'(1);

  assign memReadEn   = w_issue;
  assign memReadAddr = r_fetchPc[63:3];
  assign outValid    = (r_count != '0);
  assign outPc       = {r_qPc[r_head], 2'b00};
  assign outInst     = r_qInst[r_head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetchPc      <= RESET_PC[63:2];
      r_pendingValid <= 1'b0;
      r_pendingPc    <= '0;
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
    end else if (redirect) begin
      r_fetchPc      <= redirectPc;
      r_pendingValid <= 1'b0;
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
    end else begin
      r_pendingValid <= w_issue;
      if (w_issue) begin
        r_pendingPc <= r_fetchPc;
        r_fetchPc   <= {r_fetchPc[63:3] + 61'd1, 1'b0};
      end
      if (w_pop) begin
        r_head <= r_head + c_PTR_W'(1);
      end
      r_tail  <= r_tail + c_PTR_W'(w_pushCount);
      r_count <= r_count + w_pushCount - c_CNT_W'(w_pop);
    end
  end

  // Big-endian split: the upper word holds the lower-addressed instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        r_qPc[i]   <= '0;
        r_qInst[i] <= '0;
      end
    end else if (!redirect) begin
      if (w_pushTwo) begin
        r_qPc[r_tail]        <= {r_pendingPc[63:3], 1'b0};
        r_qInst[r_tail]      <= memReadData[63:32];
        r_qPc[w_tailNext1]   <= {r_pendingPc[63:3], 1'b1};
        r_qInst[w_tailNext1] <= memReadData[31:0];
      end else if (w_pushOne) begin
        r_qPc[r_tail]   <= r_pendingPc;
        r_qInst[r_tail] <= memReadData[31:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_queue                                               |
// | Description : Randomized bench for fetch_queue with a queue-based model.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fetch_queue;

  localparam int          QDEPTH   = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         memReadEn;
  logic [63:3]  memReadAddr;
  logic [63:0]  memReadData = '0;
  logic         redirect = 1'b0;
  logic [63:2]  redirectPc = '0;
  logic         outValid;
  logic         outReady = 1'b0;
  logic [63:0]  outPc;
  logic [31:0]  outInst;

  int checks = 0;
  int failures = 0;

  // Reference model: queue of buffered word PCs, one outstanding request.
  logic [61:0] mq[$];
  logic        mPend;
  logic [61:0] mPendPc;
  logic [61:0] mFetch;
  logic [63:0] retPc[$];
  logic [31:0] retInst[$];
  logic [63:0] resetPcV = RESET_PC;

  fetch_queue #(.QDEPTH(QDEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .memReadEn(memReadEn), .memReadAddr(memReadAddr), .memReadData(memReadData),
    .redirect(redirect), .redirectPc(redirectPc),
    .outValid(outValid), .outReady(outReady), .outPc(outPc), .outInst(outInst)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] memDw(input logic [60:0] a);
    case (a)
      61'd0:   return 64'h11111111_22222222;
      61'd1:   return 64'h33333333_44444444;
      61'd2:   return 64'hAAAAAAAA_BBBBBBBB;
      61'd3:   return 64'hCCCCCCCC_DDDDDDDD;
      default: return {a[31:0] ^ 32'h5A5A0F0F, ~a[31:0] + 32'h01234567};
    endcase
  endfunction

  function automatic logic [31:0] memWord(input logic [61:0] pc);
    logic [63:0] dw;
    dw = memDw(pc[61:1]);
    return pc[0] ? dw[31:0] : dw[63:32];
  endfunction

  // Registered-read memory; garbage on idle cycles so stale data is detectable.
  always @(posedge clk) begin
    if (memReadEn) memReadData <= memDw(memReadAddr);
    else           memReadData <= {$urandom(), $urandom()};
  end

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rd, input logic [61:0] rpc, input logic rdy, input string tag);
    logic expEn;
    @(negedge clk);
    rst_n = 1'b1; redirect = rd; redirectPc = rpc; outReady = rdy;
    #1;
    expEn = !rd && ((mq.size() + (mPend ? 2 : 0)) <= QDEPTH - 2);
    checkVal({tag, ".en"},    64'(memReadEn),   64'(expEn));
    checkVal({tag, ".addr"},  64'(memReadAddr), 64'(mFetch[61:1]));
    checkVal({tag, ".valid"}, 64'(outValid),    64'(mq.size() != 0));
    if (mq.size() != 0) begin
      checkVal({tag, ".pc"},   outPc,        {mq[0], 2'b00});
      checkVal({tag, ".inst"}, 64'(outInst), 64'(memWord(mq[0])));
    end
    if (rd) begin
      mq.delete();
      mPend  = 1'b0;
      mFetch = rpc;
    end else begin
      if (outValid && rdy) begin
        retPc.push_back(outPc);
        retInst.push_back(outInst);
      end
      if (rdy && mq.size() != 0) void'(mq.pop_front());
      if (mPend) begin
        if (!mPendPc[0]) begin
          mq.push_back({mPendPc[61:1], 1'b0});
          mq.push_back({mPendPc[61:1], 1'b1});
        end else begin
          mq.push_back(mPendPc);
        end
      end
      mPend = expEn;
      if (expEn) begin
        mPendPc = mFetch;
        mFetch  = {mFetch[61:1] + 61'd1, 1'b0};
      end
    end
  endtask

  // Drops rst_n between edges and checks outputs respond without a clock.
  task automatic asyncReset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0; redirect = 1'b0;
    #1;
    checkVal({tag, ".valid"}, 64'(outValid),    64'd0);
    checkVal({tag, ".en"},    64'(memReadEn),   64'd0);
    checkVal({tag, ".pc"},    outPc,            64'd0);
    checkVal({tag, ".inst"},  64'(outInst),     64'd0);
    checkVal({tag, ".addr"},  64'(memReadAddr), 64'(resetPcV[63:3]));
    mq.delete();
    mPend  = 1'b0;
    mFetch = resetPcV[63:2];
    @(posedge clk);
  endtask

  task automatic clearRet();
    retPc.delete();
    retInst.delete();
  endtask

  task automatic checkRun(input string tag, input logic [63:0] startPc, input int n);
    checkVal({tag, ".n"}, 64'(retPc.size() >= n), 64'd1);
    if (retPc.size() >= n) begin
      for (int i = 0; i < n; i++) begin
        checkVal({tag, ".seqpc"},   retPc[i],          startPc + 64'(4 * i));
        checkVal({tag, ".seqinst"}, 64'(retInst[i]),   64'(memWord(62'(startPc[63:2] + 62'(i)))));
      end
    end
  endtask

  logic [31:0] seqInst [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

  initial begin
    mPend = 1'b0; mPendPc = '0; mFetch = resetPcV[63:2];

    // Sequential fetch from reset
    asyncReset("rst0");
    clearRet();
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, "seq");
    checkVal("seq.n", 64'(retPc.size() >= 4), 64'd1);
    if (retPc.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        checkVal("seq.pc",   retPc[i],        64'(4 * i));
        checkVal("seq.inst", 64'(retInst[i]), 64'(seqInst[i]));
      end
    end

    // Odd-word redirect to 0x14
    clearRet();
    step(1'b1, 62'h5, 1'b1, "odd");
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, "odd");
    checkVal("odd.n", 64'(retPc.size() >= 2), 64'd1);
    if (retPc.size() >= 2) begin
      checkVal("odd.pc0",   retPc[0],        64'h14);
      checkVal("odd.inst0", 64'(retInst[0]), 64'hBBBBBBBB);
      checkVal("odd.pc1",   retPc[1],        64'h18);
      checkVal("odd.inst1", 64'(retInst[1]), 64'hCCCCCCCC);
    end

    // Backpressure saturates the queue
    asyncReset("bp.rst");
    clearRet();
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0, "bp");
    checkVal("bp.stallEn",   64'(memReadEn),   64'd0);
    checkVal("bp.stallAddr", 64'(memReadAddr), 64'd2);
    checkVal("bp.stallVal",  64'(outValid),    64'd1);
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, "bp");
    checkRun("bp", 64'h0, 6);

    // Redirect with a full queue
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, "rf");
    clearRet();
    step(1'b1, 62'h10, 1'b1, "rf");
    step(1'b0, '0, 1'b1, "rf");
    checkVal("rf.emptyAfter", 64'(outValid), 64'd0);
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, "rf");
    checkRun("rf", 64'h40, 6);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'($urandom_range(0, 1)), "ar");
    asyncReset("ar.rst");
    clearRet();
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, "ar");
    checkRun("ar", resetPcV, 4);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [61:0] rpc;
      r = $urandom_range(0, 99);
      rpc = ($urandom_range(0, 7) == 0) ? 62'h3FFF_FFFF_FFFF_FFFD
                                        : 62'({$urandom(), $urandom()});
      if (r == 0) asyncReset("rnd.rst");
      else step(r < 6, rpc, $urandom_range(0, 99) < 65, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
